muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide unit for the EX stage of the 5-stage pipeline. It runs shift-add multiply and restoring divide on a shared 64-bit accumulator, one bit per cycle. It stalls the pipeline while busy and presents the result with a one-cycle done pulse, so the EX/MEM register captures the result on the cycle the stall drops. Divide-by-zero and signed overflow are resolved in one cycle without iterating.

---
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side handshake between the EX stage and the iterative RV32M unit.
// The master drives the instruction; the slave (the unit) answers with stall/done/result.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start_e;
    logic [2:0]      funct3_e;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            stall_o;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start_e, funct3_e, src_a, src_b, flush,
        input  stall_o, done, result
    );

    modport slave (
        input  start_e, funct3_e, src_a, src_b, flush,
        output stall_o, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on a
// shared 2*XLEN accumulator, one bit per cycle, with a one-cycle done pulse.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_sequencer_if.slave   bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_q, neg_d;
    logic              a_neg_q, a_neg_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              stall;
    logic              a_sgn, b_sgn, a_neg_in, b_neg_in, is_div_in;
    logic [XLEN-1:0]   a_mag_in, b_mag_in;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic              borrow;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] step, product;
    logic [XLEN-1:0]   quo, rem, fix_res;

    // Operand conditioning for a new instruction.
    always_comb begin
        a_sgn     = (bus.funct3_e == 3'b001) || (bus.funct3_e == 3'b010) ||
                    (bus.funct3_e == 3'b100) || (bus.funct3_e == 3'b110);
        b_sgn     = (bus.funct3_e == 3'b001) || (bus.funct3_e == 3'b100) ||
                    (bus.funct3_e == 3'b110);
        a_neg_in  = a_sgn && bus.src_a[XLEN-1];
        b_neg_in  = b_sgn && bus.src_b[XLEN-1];
        a_mag_in  = a_neg_in ? -bus.src_a : bus.src_a;
        b_mag_in  = b_neg_in ? -bus.src_b : bus.src_b;
        is_div_in = bus.funct3_e[2];
    end

    // One iteration: multiply keeps {partial sum, multiplier}, divide keeps {remainder, quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        borrow   = rem_sh < {1'b0, b_q};
        div_diff = rem_sh[XLEN-1:0] - b_q;
        if (op_q[2])
            step = borrow ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                          : {div_diff, acc_q[XLEN-2:0], 1'b1};
        else
            step = {mul_sum, acc_q[XLEN-1:1]};
        product = neg_q ? -step : step;
        quo     = step[XLEN-1:0];
        rem     = step[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_res = product[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = product[2*XLEN-1:XLEN];
            3'b100:                 fix_res = neg_q ? -quo : quo;
            3'b101:                 fix_res = quo;
            3'b110:                 fix_res = a_neg_q ? -rem : rem;
            default:                fix_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        count_d  = count_q;
        acc_d    = acc_q;
        result_d = result_q;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                stall = bus.start_e && !bus.flush;
                if (stall) begin
                    op_d    = bus.funct3_e;
                    a_d     = a_mag_in;
                    b_d     = b_mag_in;
                    neg_d   = a_neg_in ^ b_neg_in;
                    a_neg_d = a_neg_in;
                    count_d = '0;
                    // Divide-by-zero and signed overflow resolve without iterating.
                    if (is_div_in && bus.src_b == '0) begin
                        result_d = bus.funct3_e[1] ? bus.src_a : ALL_ONE;
                        state_d  = DONE;
                    end else if (is_div_in && !bus.funct3_e[0] &&
                                 bus.src_a == MIN_NEG && bus.src_b == ALL_ONE) begin
                        result_d = bus.funct3_e[1] ? '0 : MIN_NEG;
                        state_d  = DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, is_div_in ? a_mag_in : b_mag_in};
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                stall   = 1'b1;
                acc_d   = step;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    result_d = fix_res;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush wins over both a new start and a completing iteration.
        if (bus.flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.stall_o = stall && !rst;
    assign bus.done    = (state_q == DONE) && !rst;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model with a cycle-level
// latency model, directed vectors and randomized operations.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.XLEN(32)) bus ();
    muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // model state
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // {special, value}: result from plain signed/unsigned arithmetic
    function automatic logic [32:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax, bx, p;
        logic [31:0] v;
        logic        sp;
        sp = 1'b0;
        ax = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        bx = (f == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ax * bx;
        v  = '0;
        if (f == 3'd0) v = p[31:0];
        else if (f < 3'd4) v = p[63:32];
        else if (b == 32'h0) begin
            sp = 1'b1;
            v  = f[1] ? a : 32'hFFFF_FFFF;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            sp = 1'b1;
            v  = f[1] ? 32'h0 : 32'h8000_0000;
        end else begin
            case (f)
                3'd4:    v = 32'($signed(a) / $signed(b));
                3'd5:    v = a / b;
                3'd6:    v = 32'($signed(a) % $signed(b));
                default: v = a % b;
            endcase
        end
        return {sp, v};
    endfunction

    task automatic model_step();
        logic [32:0] r;
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_res = '0;
        end else if (bus.flush) begin
            m_left = 0; m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_done = 1'b1; m_res = m_pend; end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (bus.start_e) begin
            r = ref_op(bus.funct3_e, bus.src_a, bus.src_b);
            if (r[32]) begin m_done = 1'b1; m_res = r[31:0]; end
            else begin m_left = 32; m_pend = r[31:0]; end
        end
    endtask

    task automatic compare();
        logic exp_stall;
        exp_stall = !rst && (m_left > 0 || (!m_done && bus.start_e && !bus.flush));
        chk("stall_o", 32'(bus.stall_o), 32'(exp_stall));
        chk("done", 32'(bus.done), 32'(!rst && m_done));
        chk("result", bus.result, m_res);
    endtask

    // Drive one op at cycle 0 and return the cycle index of its done pulse.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(posedge clk); #2;
        bus.start_e = 1'b1; bus.funct3_e = f; bus.src_a = a; bus.src_b = b;
        lat = 0;
        @(negedge clk);
        while (!bus.done && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        res = bus.result;
    endtask

    task automatic watch_no_done(input string name, input int n);
        logic saw;
        saw = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) saw = 1'b1;
        end
        chk(name, 32'(saw), 32'h0);
    endtask

    localparam int NV = 13;
    logic [2:0]  t_f  [NV] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd5, 3'd7, 3'd6, 3'd7, 3'd4};
    logic [31:0] t_a  [NV] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd5, 32'd100,
                               32'h80000000, 32'd5, 32'h80000000};
    logic [31:0] t_b  [NV] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd2, 32'd2, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF};
    logic [31:0] t_e  [NV] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'h1,
                               32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'hFFFFFFFF, 32'd2,
                               32'h0, 32'd5, 32'h80000000};
    int          t_l  [NV] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 33, 1, 1, 1};

    initial begin
        logic [31:0] res, a, b;
        logic [32:0] r;
        logic [2:0]  f;
        int          lat, k;

        rst = 1'b1;
        bus.start_e = 1'b0; bus.funct3_e = '0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        fork
            forever begin @(posedge clk); model_step(); end
            forever begin @(negedge clk); compare(); end
        join_none

        @(negedge clk);
        chk("reset_stall", 32'(bus.stall_o), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        chk("reset_result", bus.result, 32'h0);

        // Directed vectors, back-to-back; each pins the model and the DUT.
        for (int i = 0; i < NV; i++) begin
            r = ref_op(t_f[i], t_a[i], t_b[i]);
            chk($sformatf("model_vec%0d", i), r[31:0], t_e[i]);
            run_op(t_f[i], t_a[i], t_b[i], res, lat);
            chk($sformatf("dut_vec%0d", i), res, t_e[i]);
            chk($sformatf("lat_vec%0d", i), 32'(lat), 32'(t_l[i]));
        end

        // Flush at count=10 aborts and keeps the previous result.
        @(posedge clk); #2;
        bus.start_e = 1'b1; bus.funct3_e = 3'd0; bus.src_a = 32'd9; bus.src_b = 32'd11;
        repeat (11) @(posedge clk);
        #2 bus.flush = 1'b1; bus.start_e = 1'b0;
        @(posedge clk); #2 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", 32'(bus.stall_o), 32'h0);
        chk("flush_done", 32'(bus.done), 32'h0);
        chk("flush_result", bus.result, 32'h8000_0000);
        watch_no_done("flush_no_done", 40);
        run_op(3'd0, 32'd3, 32'd4, res, lat);
        chk("post_flush_mul", res, 32'd12);
        chk("post_flush_lat", 32'(lat), 32'd33);

        // Reset at count=20 aborts and clears result.
        @(posedge clk); #2;
        bus.start_e = 1'b1; bus.funct3_e = 3'd5; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        repeat (21) @(posedge clk);
        #2 rst = 1'b1; bus.start_e = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall_o), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_result", bus.result, 32'h0);
        watch_no_done("rst_no_done", 40);

        // Randomized operations with corner-biased operands and occasional flushes.
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            k = $urandom_range(0, 9);
            if (k == 0) b = 32'h0;
            else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (k == 2) b = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk); #2;
                bus.start_e = 1'b1; bus.funct3_e = f; bus.src_a = a; bus.src_b = b;
                repeat ($urandom_range(1, 40)) @(posedge clk);
                #2 bus.flush = 1'b1; bus.start_e = 1'b0;
                @(posedge clk); #2 bus.flush = 1'b0;
            end else begin
                r = ref_op(f, a, b);
                run_op(f, a, b, res, lat);
                chk($sformatf("rand%0d_f%0d", i, f), res, r[31:0]);
                chk($sformatf("rand%0d_lat", i), 32'(lat), r[32] ? 32'd1 : 32'd33);
                if ($urandom_range(0, 1) == 0) begin
                    @(posedge clk); #2 bus.start_e = 1'b0;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
        end

        @(posedge clk); #2 bus.start_e = 1'b0;
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
